// File: rtl/td4_state_dump_if.sv
// Host-side byte link of the TD4 readback transmitter.
// The dumper is the slave; the off-chip host (or bench) is the master.
interface td4_state_dump_if;
  logic       start;
  logic       mode;
  logic       ack;
  logic [7:0] dout;
  logic       dout_valid;
  logic       busy;
  logic       mem_lock;
  logic       done;

  modport slave (
    input  start,
    input  mode,
    input  ack,
    output dout,
    output dout_valid,
    output busy,
    output mem_lock,
    output done
  );

  modport master (
    output start,
    output mode,
    output ack,
    input  dout,
    input  dout_valid,
    input  busy,
    input  mem_lock,
    input  done
  );
endinterface

// File: rtl/td4_state_dump.sv
// TD4 readback transmitter: streams program memory or a CPU state
// snapshot out one byte at a time over a four-phase valid/ack link.
module td4_state_dump #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] HDR_MEM     = 8'hA5,
  parameter logic [7:0] HDR_SNAP    = 8'h5A
) (
  input  logic       clk,
  input  logic       rst,
  td4_state_dump_if.slave host,
  input  logic [3:0] mem_opcode,
  input  logic [3:0] mem_immediate,
  input  logic [3:0] pc,
  input  logic [3:0] reg_a,
  input  logic [3:0] reg_b,
  input  logic [3:0] reg_out,
  input  logic       carry,
  output logic [3:0] mem_addr
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    PRESENT,
    RELEASE,
    FINISH
  } state_t;

  localparam logic [4:0] LAST_MEM  = 5'd17;
  localparam logic [4:0] LAST_SNAP = 5'd4;

  state_t state;

  logic [SYNC_STAGES-1:0] sync;
  logic ack_s;

  logic       mode_q;
  logic [3:0] s_pc;
  logic [3:0] s_a;
  logic [3:0] s_b;
  logic [3:0] s_out;
  logic       s_c;

  logic [4:0] idx;
  logic [7:0] csum;
  logic [7:0] dout;
  logic       dout_valid;
  logic       busy;
  logic       done;

  logic       is_hdr;
  logic       is_last;
  logic       is_mdata;
  logic       is_sdata;
  logic [7:0] snap_byte;
  logic [7:0] byte_nxt;

  assign ack_s = sync[SYNC_STAGES-1];

  assign is_hdr   = (idx == 5'd0);
  assign is_last  = mode_q ? (idx == LAST_SNAP)
                           : (idx == LAST_MEM);
  assign is_mdata = !mode_q && !is_hdr && !is_last;
  assign is_sdata = mode_q && !is_hdr && !is_last;

  always_comb begin
    snap_byte = {7'b0, s_c};
    if (idx == 5'd1)
      snap_byte = {s_pc, s_out};
    else if (idx == 5'd2)
      snap_byte = {s_a, s_b};
  end

  always_comb begin
    byte_nxt = csum;
    unique case (1'b1)
      is_hdr:   byte_nxt = mode_q ? HDR_SNAP : HDR_MEM;
      is_last:  byte_nxt = csum;
      is_mdata: byte_nxt = {mem_opcode, mem_immediate};
      is_sdata: byte_nxt = snap_byte;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      sync       <= '0;
      mode_q     <= 1'b0;
      s_pc       <= 4'd0;
      s_a        <= 4'd0;
      s_b        <= 4'd0;
      s_out      <= 4'd0;
      s_c        <= 1'b0;
      idx        <= 5'd0;
      csum       <= 8'd0;
      dout       <= 8'd0;
      dout_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      mem_addr   <= 4'd0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], host.ack};
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (host.start) begin
            mode_q <= host.mode;
            if (host.mode) begin
              s_pc  <= pc;
              s_a   <= reg_a;
              s_b   <= reg_b;
              s_out <= reg_out;
              s_c   <= carry;
            end
            idx   <= 5'd0;
            csum  <= 8'd0;
            busy  <= 1'b1;
            state <= LOAD;
          end
        end
        LOAD: begin
          dout       <= byte_nxt;
          dout_valid <= 1'b1;
          if (!is_hdr && !is_last)
            csum <= csum + byte_nxt;
          state <= PRESENT;
        end
        PRESENT: begin
          if (ack_s) begin
            dout_valid <= 1'b0;
            state      <= RELEASE;
          end
        end
        RELEASE: begin
          if (!ack_s) begin
            if (is_last) begin
              done  <= 1'b1;
              state <= FINISH;
            end else begin
              idx <= idx + 5'd1;
              // next data byte N reads address N-1 == current idx
              if (!mode_q && idx < 5'd16)
                mem_addr <= idx[3:0];
              state <= LOAD;
            end
          end
        end
        FINISH: begin
          busy     <= 1'b0;
          mem_addr <= 4'd0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign host.dout       = dout;
  assign host.dout_valid = dout_valid;
  assign host.busy       = busy;
  assign host.mem_lock   = busy;
  assign host.done       = done;

endmodule

// File: tb/tb_td4_state_dump.sv
// Bench for td4_state_dump: host model, gated program memory and
// a frame-level reference built from memory image / CPU values.
module tb_td4_state_dump;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  td4_state_dump_if hif();

  logic [3:0] mem_addr;
  logic [3:0] cpu_pc;
  logic [3:0] cpu_a;
  logic [3:0] cpu_b;
  logic [3:0] cpu_out;
  logic       cpu_c;

  logic [7:0] mem [16];
  logic [7:0] img [16];
  logic       wr_en = 1'b0;
  logic [3:0] wr_addr = 4'd0;
  logic [7:0] wr_data = 8'd0;

  // top-level write strobe gated by mem_lock
  always @(posedge clk)
    if (wr_en && !hif.mem_lock)
      mem[wr_addr] <= wr_data;

  logic [7:0] rd_word;
  assign rd_word = mem[mem_addr];

  td4_state_dump dut (
    .clk           (clk),
    .rst           (rst),
    .host          (hif),
    .mem_opcode    (rd_word[7:4]),
    .mem_immediate (rd_word[3:0]),
    .pc            (cpu_pc),
    .reg_a         (cpu_a),
    .reg_b         (cpu_b),
    .reg_out       (cpu_out),
    .carry         (cpu_c),
    .mem_addr      (mem_addr)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;
  bit in_frame = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];

  always @(negedge clk)
    if (hif.done === 1'b1)
      done_cnt++;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic rand_cpu();
    cpu_pc  = 4'($urandom);
    cpu_a   = 4'($urandom);
    cpu_b   = 4'($urandom);
    cpu_out = 4'($urandom);
    cpu_c   = 1'($urandom);
  endtask

  task automatic mem_load();
    for (int a = 0; a < 16; a++) begin
      wr_addr = 4'(a);
      wr_data = img[a];
      wr_en   = 1'b1;
      @(negedge clk);
    end
    wr_en = 1'b0;
  endtask

  // reference frame from the frame rules, plain arithmetic
  task automatic build(input bit m);
    int s;
    int v1;
    int v2;
    int v3;
    exp_q.delete();
    s = 0;
    if (!m) begin
      exp_q.push_back(8'hA5);
      for (int a = 0; a < 16; a++) begin
        exp_q.push_back(img[a]);
        s += int'(img[a]);
      end
    end else begin
      v1 = int'(cpu_pc) * 16 + int'(cpu_out);
      v2 = int'(cpu_a) * 16 + int'(cpu_b);
      v3 = int'(cpu_c);
      exp_q.push_back(8'h5A);
      exp_q.push_back(8'(v1));
      exp_q.push_back(8'(v2));
      exp_q.push_back(8'(v3));
      s = v1 + v2 + v3;
    end
    exp_q.push_back(8'(s % 256));
  endtask

  // called at a negedge; returns at a negedge with ack low
  task automatic recv_byte(output logic [7:0] b);
    int w;
    int d;
    w = 0;
    while (hif.dout_valid !== 1'b1 && w < 400) begin
      @(negedge clk);
      w++;
    end
    check("valid_wait", hif.dout_valid, 1);
    b = hif.dout;
    d = $urandom_range(0, 3);
    repeat (d) begin
      @(negedge clk);
      check("dout_stable", hif.dout, b);
    end
    hif.ack = 1'b1;
    @(negedge clk);
    w = 0;
    while (hif.dout_valid === 1'b1 && w < 400) begin
      check("dout_hold", hif.dout, b);
      @(negedge clk);
      w++;
    end
    check("valid_fall", hif.dout_valid, 0);
    repeat ($urandom_range(0, 2)) @(negedge clk);
    hif.ack = 1'b0;
  endtask

  task automatic run_frame(input bit m, input bit poke);
    logic [7:0] b;
    int d0;
    int w;
    @(negedge clk);
    hif.mode  = m;
    hif.start = 1'b1;
    @(negedge clk);
    hif.start = 1'b0;
    in_frame  = 1'b1;
    d0 = done_cnt;
    rand_cpu();
    rx_q.delete();
    foreach (exp_q[i]) begin
      recv_byte(b);
      rx_q.push_back(b);
      check("frame_byte", b, exp_q[i]);
    end
    in_frame = 1'b0;
    if (poke) begin
      w = 0;
      while (hif.done !== 1'b1 && w < 50) begin
        @(negedge clk);
        w++;
      end
      check("finish_seen", hif.done, 1);
      hif.start = 1'b1;
      hif.mode  = 1'b0;
      @(negedge clk);
      hif.start = 1'b0;
    end
    repeat (6) @(negedge clk);
    check("done_pulses", done_cnt - d0, 1);
    check("idle_busy", hif.busy, 0);
    check("idle_addr", mem_addr, 0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    int k;
    int d0;
    int w;
    hif.start = 1'b0;
    hif.mode  = 1'b0;
    hif.ack   = 1'b0;
    cpu_pc = 4'd0; cpu_a = 4'd0; cpu_b = 4'd0;
    cpu_out = 4'd0; cpu_c = 1'b0;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_valid", hif.dout_valid, 0);
    check("rst_busy", hif.busy, 0);
    check("rst_done", hif.done, 0);
    check("rst_dout", hif.dout, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_lock", hif.mem_lock, 0);
    rst = 1'b0;

    // all-zero memory
    for (int a = 0; a < 16; a++) img[a] = 8'h00;
    mem_load();
    build(1'b0);
    run_frame(1'b0, 1'b0);
    check("zero_len", rx_q.size(), 18);

    // pattern {i, ~i}
    for (int a = 0; a < 16; a++) img[a] = 8'(a * 16 + (15 - a));
    mem_load();
    build(1'b0);
    run_frame(1'b0, 1'b0);
    check("pat_b1", rx_q[1], 8'h0F);
    check("pat_b16", rx_q[16], 8'hF0);
    check("pat_csum", rx_q[17], 8'hF8);

    // directed snapshot, CPU changes after start
    cpu_pc = 4'h3; cpu_out = 4'hC; cpu_a = 4'h5;
    cpu_b = 4'hA; cpu_c = 1'b1;
    exp_q = '{8'h5A, 8'h3C, 8'h5A, 8'h01, 8'h97};
    run_frame(1'b1, 1'b0);

    // handshake timing
    cpu_pc = 4'h1; cpu_out = 4'h2; cpu_a = 4'h3;
    cpu_b = 4'h4; cpu_c = 1'b0;
    build(1'b1);
    @(negedge clk);
    hif.mode  = 1'b1;
    hif.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    hif.start = 1'b0;
    d0 = done_cnt;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("valid_n2", hif.dout_valid, 1);
    check("busy_n2", hif.busy, 1);
    check("hdr_snap", hif.dout, exp_q[0]);
    @(negedge clk);
    hif.ack = 1'b1;
    k = 0;
    do begin
      @(posedge clk);
      #1;
      k++;
      if (hif.dout_valid === 1'b1)
        check("hold_t", hif.dout, exp_q[0]);
    end while (hif.dout_valid === 1'b1 && k < 20);
    check("ack_rise_edges", k, 3);
    @(negedge clk);
    hif.ack = 1'b0;
    k = 0;
    do begin
      @(posedge clk);
      #1;
      k++;
    end while (hif.dout_valid !== 1'b1 && k < 20);
    check("ack_fall_edges", k, 4);
    @(negedge clk);
    for (int i = 1; i < 5; i++) begin
      recv_byte(b);
      check("timing_byte", b, exp_q[i]);
    end
    repeat (6) @(negedge clk);
    check("timing_done", done_cnt - d0, 1);

    // reset mid-frame during byte 5
    for (int a = 0; a < 16; a++) img[a] = 8'($urandom);
    mem_load();
    build(1'b0);
    @(negedge clk);
    hif.mode  = 1'b0;
    hif.start = 1'b1;
    @(negedge clk);
    hif.start = 1'b0;
    d0 = done_cnt;
    for (int i = 0; i < 5; i++) begin
      recv_byte(b);
      check("pre_rst_byte", b, exp_q[i]);
    end
    w = 0;
    while (hif.dout_valid !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("byte5_valid", hif.dout_valid, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_valid", hif.dout_valid, 0);
    check("mid_rst_busy", hif.busy, 0);
    check("mid_rst_dout", hif.dout, 0);
    check("mid_rst_addr", mem_addr, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("mid_rst_nodone", done_cnt - d0, 0);
    check("mid_rst_idle", hif.busy, 0);
    run_frame(1'b0, 1'b0);

    // start and rst together
    @(negedge clk);
    hif.start = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    hif.start = 1'b0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("start_rst_busy", hif.busy, 0);
    check("start_rst_valid", hif.dout_valid, 0);

    // start pokes and write strobes during a dump
    for (int a = 0; a < 16; a++) img[a] = 8'($urandom);
    mem_load();
    build(1'b0);
    fork
      run_frame(1'b0, 1'b1);
      begin
        repeat (2) @(negedge clk);
        while (1) begin
          @(negedge clk);
          if (!in_frame) begin
            wr_en = 1'b0;
            hif.start = 1'b0;
            break;
          end
          check("lock_high", hif.mem_lock, 1);
          wr_en     = 1'($urandom);
          wr_addr   = 4'($urandom);
          wr_data   = 8'($urandom);
          hif.start = 1'($urandom);
          hif.mode  = 1'($urandom);
        end
      end
    join
    for (int a = 0; a < 16; a++)
      check("mem_kept", mem[a], img[a]);

    // ack already high at start
    hif.ack = 1'b1;
    rand_cpu();
    build(1'b1);
    repeat (4) @(negedge clk);
    hif.mode  = 1'b1;
    hif.start = 1'b1;
    @(negedge clk);
    hif.start = 1'b0;
    d0 = done_cnt;
    w = 0;
    while (hif.dout_valid !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("early_ack_valid", hif.dout_valid, 1);
    check("early_ack_hdr", hif.dout, exp_q[0]);
    w = 0;
    while (hif.dout_valid === 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("early_ack_fall", hif.dout_valid, 0);
    hif.ack = 1'b0;
    for (int i = 1; i < 5; i++) begin
      recv_byte(b);
      check("early_ack_byte", b, exp_q[i]);
    end
    repeat (6) @(negedge clk);
    check("early_ack_done", done_cnt - d0, 1);

    // randomized frames
    for (int t = 0; t < 6; t++) begin
      bit m;
      m = 1'($urandom);
      for (int a = 0; a < 16; a++) img[a] = 8'($urandom);
      mem_load();
      rand_cpu();
      build(m);
      run_frame(m, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
